// File: rtl/snitch_tohost_arbiter.sv
// snitch_tohost_arbiter: shares the tohost/fromhost mailbox among cores.
// Round-robin grant, host handoff, reply routing and sticky exit decode.
module snitch_tohost_arbiter #(
  parameter int unsigned NrCores   = 8,
  parameter int unsigned DataWidth = 64,
  localparam int unsigned CoreW    = (NrCores > 1) ? $clog2(NrCores) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NrCores-1:0]           req_valid_i,
  input  logic [NrCores*DataWidth-1:0] req_data_i,
  output logic [NrCores-1:0]           req_ready_o,
  output logic                         host_valid_o,
  input  logic                         host_ready_i,
  output logic [DataWidth-1:0]         host_data_o,
  output logic [CoreW-1:0]             host_core_o,
  input  logic                         fromhost_valid_i,
  input  logic [DataWidth-1:0]         fromhost_data_i,
  output logic [NrCores-1:0]           resp_valid_o,
  output logic [DataWidth-1:0]         resp_data_o,
  output logic                         exit_o,
  output logic [DataWidth-2:0]         exit_code_o
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    EXIT
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CoreW-1:0]      r_rr;
  logic [CoreW-1:0]      r_core;
  logic [DataWidth-1:0]  r_data;
  logic [NrCores-1:0]    r_resp_valid;
  logic [DataWidth-1:0]  r_resp_data;

  logic                  w_gvalid;
  logic [CoreW-1:0]      w_gidx;
  logic [CoreW-1:0]      w_rr_nxt;
  logic [DataWidth-1:0]  w_gdata;
  logic                  w_take;
  logic                  w_resp;

  // Round-robin pick: lowest requester at or above the pointer, else wrap.
  always_comb begin
    w_gvalid = 1'b0;
    w_gidx   = '0;
    for (int i = 0; i < NrCores; i++) begin
      if (!w_gvalid && req_valid_i[i] && (CoreW'(i) >= r_rr)) begin
        w_gvalid = 1'b1;
        w_gidx   = CoreW'(i);
      end
    end
    for (int i = 0; i < NrCores; i++) begin
      if (!w_gvalid && req_valid_i[i]) begin
        w_gvalid = 1'b1;
        w_gidx   = CoreW'(i);
      end
    end
  end

  // Data of the picked core and the pointer value after it.
  always_comb begin
    w_gdata = '0;
    for (int i = 0; i < NrCores; i++) begin
      if (w_gidx == CoreW'(i)) begin
        w_gdata = req_data_i[i*DataWidth +: DataWidth];
      end
    end
    if (w_gidx == CoreW'(NrCores - 1)) begin
      w_rr_nxt = '0;
    end else begin
      w_rr_nxt = w_gidx + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and mailbox-side outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_take       = 1'b0;
    w_resp       = 1'b0;
    req_ready_o  = '0;
    host_valid_o = 1'b0;
    exit_o       = 1'b0;
    exit_code_o  = '0;
    unique case (r_state)
      IDLE: begin
        if (w_gvalid) begin
          w_take      = 1'b1;
          req_ready_o = NrCores'(1) << w_gidx;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        host_valid_o = 1'b1;
        if (host_ready_i) begin
          w_state_nxt = r_data[0] ? EXIT : WAIT;
        end
      end
      WAIT: begin
        if (fromhost_valid_i) begin
          w_resp      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      EXIT: begin
        exit_o      = 1'b1;
        exit_code_o = r_data[DataWidth-1:1];
      end
    endcase
  end

  // Captured request, pointer and registered reply pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr         <= '0;
      r_core       <= '0;
      r_data       <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= '0;
      if (w_take) begin
        r_data <= w_gdata;
        r_core <= w_gidx;
        r_rr   <= w_rr_nxt;
      end
      if (w_resp) begin
        r_resp_valid <= NrCores'(1) << r_core;
        r_resp_data  <= fromhost_data_i;
      end
    end
  end

  assign host_data_o  = r_data;
  assign host_core_o  = r_core;
  assign resp_valid_o = r_resp_valid;
  assign resp_data_o  = r_resp_data;

endmodule

// File: tb/tb_snitch_tohost_arbiter.sv
// tb_snitch_tohost_arbiter: directed + randomized mailbox transactions
// checked against a transaction-level reference model.
module tb_snitch_tohost_arbiter;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic [7:0]   req_valid;
  logic [511:0] req_data;
  logic [7:0]   req_ready;
  logic         host_valid;
  logic         host_ready;
  logic [63:0]  host_data;
  logic [2:0]   host_core;
  logic         fh_valid;
  logic [63:0]  fh_data;
  logic [7:0]   resp_valid;
  logic [63:0]  resp_data;
  logic         exit_w;
  logic [62:0]  exit_code;

  int           checks = 0;
  int           errors = 0;
  int           m_rr = 0;
  logic [63:0]  m_resp_data = '0;
  logic [63:0]  td [8];

  snitch_tohost_arbiter #(
    .NrCores   (8),
    .DataWidth (64)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid),
    .req_data_i       (req_data),
    .req_ready_o      (req_ready),
    .host_valid_o     (host_valid),
    .host_ready_i     (host_ready),
    .host_data_o      (host_data),
    .host_core_o      (host_core),
    .fromhost_valid_i (fh_valid),
    .fromhost_data_i  (fh_data),
    .resp_valid_o     (resp_valid),
    .resp_data_o      (resp_data),
    .exit_o           (exit_w),
    .exit_code_o      (exit_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] v, input int rr);
    for (int k = 0; k < 8; k++) begin
      if (v[(rr + k) % 8]) return (rr + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [63:0] rnd_even();
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[0] = 1'b0;
    return r;
  endfunction

  task automatic check_reset();
    chk("rst_req_ready", {56'd0, req_ready}, 64'd0);
    chk("rst_host_valid", {63'd0, host_valid}, 64'd0);
    chk("rst_host_data", host_data, 64'd0);
    chk("rst_host_core", {61'd0, host_core}, 64'd0);
    chk("rst_resp_valid", {56'd0, resp_valid}, 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_exit", {63'd0, exit_w}, 64'd0);
    chk("rst_exit_code", {1'b0, exit_code}, 64'd0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    host_ready = 1'b0;
    fh_valid = 1'b0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    m_rr = 0;
    m_resp_data = '0;
    check_reset();
  endtask

  task automatic txn(input logic [7:0] v, input int hdel, input int fdel,
                     input logic [63:0] fh, input bit spur,
                     input bit rst_wait, output int g);
    int gi;
    req_valid = v;
    for (int i = 0; i < 8; i++) req_data[i*64 +: 64] = td[i];
    #1;
    gi = pick(v, m_rr);
    g = gi;
    chk("grant", {56'd0, req_ready}, (gi < 0) ? 64'd0 : (64'd1 << gi));
    if (gi < 0) return;
    tick();
    m_rr = (gi + 1) % 8;
    req_valid[gi] = 1'b0;
    #1;
    chk("send_valid", {63'd0, host_valid}, 64'd1);
    chk("send_data", host_data, td[gi]);
    chk("send_core", {61'd0, host_core}, 64'(gi));
    chk("send_ready0", {56'd0, req_ready}, 64'd0);
    chk("resp_hold", resp_data, m_resp_data);
    chk("resp_idle", {56'd0, resp_valid}, 64'd0);
    repeat (hdel) begin
      fh_valid = spur ? 1'($urandom % 2) : 1'b0;
      fh_data = {$urandom, $urandom};
      tick();
      fh_valid = 1'b0;
      chk("stall_valid", {63'd0, host_valid}, 64'd1);
      chk("stall_data", host_data, td[gi]);
      chk("stall_resp", {56'd0, resp_valid}, 64'd0);
    end
    host_ready = 1'b1;
    tick();
    host_ready = 1'b0;
    chk("post_host_valid", {63'd0, host_valid}, 64'd0);
    chk("post_ready0", {56'd0, req_ready}, 64'd0);
    if (td[gi][0]) begin
      chk("exit", {63'd0, exit_w}, 64'd1);
      chk("exit_code", {1'b0, exit_code}, td[gi] >> 1);
      return;
    end
    chk("no_exit", {63'd0, exit_w}, 64'd0);
    if (rst_wait) begin
      do_reset();
      fh_valid = 1'b1;
      fh_data = fh;
      tick();
      fh_valid = 1'b0;
      chk("rst_wait_noresp", {56'd0, resp_valid}, 64'd0);
      chk("rst_wait_data", resp_data, 64'd0);
      return;
    end
    repeat (fdel) begin
      tick();
      chk("wait_resp", {56'd0, resp_valid}, 64'd0);
      chk("wait_ready0", {56'd0, req_ready}, 64'd0);
    end
    fh_valid = 1'b1;
    fh_data = fh;
    tick();
    fh_valid = 1'b0;
    m_resp_data = fh;
    chk("resp_valid", {56'd0, resp_valid}, 64'd1 << gi);
    chk("resp_data", resp_data, fh);
  endtask

  initial begin
    int g;
    logic [7:0] v;
    req_valid = '0;
    req_data = '0;
    host_ready = 1'b0;
    fh_valid = 1'b0;
    fh_data = '0;
    for (int i = 0; i < 8; i++) td[i] = '0;
    rst_ni = 1'b0;
    repeat (2) tick();
    do_reset();

    td[2] = 64'h100;
    txn(8'b0000_0100, 0, 1, 64'h5A, 1'b0, 1'b0, g);
    chk("t1_core", 64'(g), 64'd2);
    tick();
    chk("t1_pulse_end", {56'd0, resp_valid}, 64'd0);
    chk("t1_hold", resp_data, 64'h5A);
    chk("t1_exit", {63'd0, exit_w}, 64'd0);

    do_reset();
    for (int n = 0; n < 9; n++) begin
      for (int i = 0; i < 8; i++) td[i] = rnd_even();
      txn(8'hFF, $urandom_range(0, 3), $urandom_range(0, 3),
          {$urandom, $urandom}, 1'b1, 1'b0, g);
      chk("rr_order", 64'(g), 64'(n % 8));
    end

    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 8; i++) td[i] = rnd_even();
      v = 8'($urandom_range(1, 255));
      txn(v, $urandom_range(0, 2), $urandom_range(0, 2),
          {$urandom, $urandom}, 1'b1, 1'b0, g);
    end

    req_valid = '0;
    fh_valid = 1'b1;
    fh_data = 64'hDEAD;
    tick();
    fh_valid = 1'b0;
    chk("idle_spur_resp", {56'd0, resp_valid}, 64'd0);
    chk("idle_spur_data", resp_data, m_resp_data);

    td[3] = rnd_even();
    txn(8'b0000_1000, 20, 0, 64'h1234, 1'b1, 1'b0, g);

    td[6] = rnd_even();
    txn(8'b0100_0000, 1, 1, 64'h77, 1'b0, 1'b1, g);
    for (int i = 0; i < 8; i++) td[i] = rnd_even();
    txn(8'hFF, 0, 0, 64'h99, 1'b0, 1'b0, g);
    chk("rr_restart", 64'(g), 64'd0);

    td[5] = 64'h7;
    txn(8'b0010_0000, 2, 0, 64'h0, 1'b1, 1'b0, g);
    req_valid = 8'hFF;
    repeat (5) begin
      fh_valid = 1'($urandom % 2);
      #1;
      chk("exit_ready0", {56'd0, req_ready}, 64'd0);
      tick();
      fh_valid = 1'b0;
      chk("exit_noresp", {56'd0, resp_valid}, 64'd0);
      chk("exit_sticky", {63'd0, exit_w}, 64'd1);
      chk("exit_code3", {1'b0, exit_code}, 64'd3);
      chk("exit_hv0", {63'd0, host_valid}, 64'd0);
    end

    do_reset();
    td[0] = 64'h1;
    txn(8'b0000_0001, 0, 0, 64'h0, 1'b0, 1'b0, g);
    chk("exit0_core", 64'(g), 64'd0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snitch_tohost_arbiter.md
# snitch_tohost_arbiter

Synthesizable controller that shares the single host-target mailbox (tohost/fromhost, fesvr protocol) between `NrCores` requesters. Round-robin arbitration grants one tohost write at a time, presents it to the host poller, and routes the fromhost reply back to the issuing core. An odd tohost value is decoded as program exit: the exit code is latched and the mailbox is frozen until reset. It sits between the cluster's core-side mailbox ports and the testbench/host polling logic.

## Interface
- `NrCores`, default 8: number of requesters; must be >= 1.
- `DataWidth`, default 64: tohost/fromhost word width; must be >= 2.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `req_valid_i` in NrCores: per-core tohost write request.
- `req_data_i` in NrCores*DataWidth: per-core tohost value, core i at bits [i*DataWidth +: DataWidth].
- `req_ready_o` out NrCores: one-hot grant, accepts that core's write this cycle.
- `host_valid_o` out 1: tohost value pending for host.
- `host_ready_i` in 1: host consumes tohost value.
- `host_data_o` out DataWidth: pending tohost value.
- `host_core_o` out max(1,$clog2(NrCores)): index of issuing core.
- `fromhost_valid_i` in 1: host reply strobe (single cycle, no backpressure).
- `fromhost_data_i` in DataWidth: host reply value.
- `resp_valid_o` out NrCores: one-cycle reply pulse to issuing core.
- `resp_data_o` out DataWidth: reply value, shared by all cores.
- `exit_o` out 1: sticky, program finished.
- `exit_code_o` out DataWidth-1: tohost value >> 1, valid while `exit_o`.

## Operation
- FSM states: IDLE, SEND, WAIT, EXIT.
- IDLE: `req_ready_o` = combinational round-robin pick among `req_valid_i`, starting at pointer `rr_q`; at most one bit set; zero if no request. On grant to core g: capture data and g, `rr_q` <= (g+1) mod NrCores, go SEND.
- SEND: `host_valid_o`=1, `host_data_o`/`host_core_o` stable. On `host_ready_i`: if captured data[0]=1, go EXIT; else go WAIT.
- WAIT: on `fromhost_valid_i`: register `resp_valid_o[g]`=1 and `resp_data_o`=`fromhost_data_i` for one cycle, go IDLE.
- EXIT: `exit_o`=1, `exit_code_o`=captured data[DataWidth-1:1]; terminal until reset. `req_ready_o`=0, `host_valid_o`=0, `fromhost_valid_i` ignored.
- `req_ready_o` is zero in every state except IDLE; requesters hold `req_valid_i`/data until granted.
- `fromhost_valid_i` outside WAIT is dropped; no response generated.
- `resp_data_o` holds its last value when `resp_valid_o` is zero.
- Exit code 0 (tohost = 1) is a successful exit; nonzero code is failure. The block only reports, it does not judge.
- NrCores=1: arbiter degenerates to pass-through, `host_core_o`=0.

## Timing
- Reset (`rst_ni`=0 at a clock edge): state IDLE, `rr_q`=0, `req_ready_o`=0 until the next cycle's requests are evaluated, `host_valid_o`=0, `host_data_o`=0, `host_core_o`=0, `resp_valid_o`=0, `resp_data_o`=0, `exit_o`=0, `exit_code_o`=0. Reset mid-transaction, including in EXIT, discards everything; nothing reaches host or cores.
- Grant in cycle N -> `host_valid_o` high from N+1.
- `host_ready_i` in cycle M -> WAIT from M+1, or EXIT with `exit_o` high from M+1.
- `fromhost_valid_i` in cycle K of WAIT -> `resp_valid_o` pulse in K+1; IDLE in K+1, so a new grant is possible in K+1.
- Minimum request-to-response: grant N, host_ready N+1, fromhost N+2, resp N+3.
- Simultaneous `req_valid_i` with `resp_valid_o` in the same cycle is legal; the grant uses the already-advanced `rr_q`.

## Test plan
- Single core 2 writes 0x100; host_ready next cycle; fromhost 0x5A two cycles later -> host_core_o=2, host_data_o=0x100, resp_valid_o=8'b0000_0100 for one cycle with resp_data_o=0x5A; exit_o stays 0.
- All 8 cores request continuously with non-exit values -> grant order 0,1,...,7,0; no core is granted twice before the others are served.
- Core 5 writes 0x7 (code 3) -> exit_o=1, exit_code_o=3 the cycle after host_ready; later requests never get req_ready_o; fromhost pulses produce no resp_valid_o.
- Core 0 writes 0x1 -> exit_o=1, exit_code_o=0 (success).
- host_ready_i held low 20 cycles -> host_valid_o/host_data_o stable throughout; spurious fromhost_valid_i in SEND/IDLE ignored.
- Assert rst_ni=0 in WAIT and in EXIT -> all outputs return to reset values next cycle; rr_q restarts at core 0.
